crc_frame_ctrl: RTL and testbench
=================================

// Module: crc_frame_ctrl
// PURPOSE
//  Frame-level sequencer for one crc32_d32 engine. Takes 32-bit words in SOP/EOP frames and runs in one of two modes.
//  Generate mode: passes the frame through, then appends the CRC word.
//  Check mode: passes the frame (last word = received CRC) through and reports pass/fail (residue == 0).
//  Drives the engine's clear/data/valid pins; sits between frame source and sink on the cache ingress/egress path.
// PARAMETERS
//  DW      32   data/CRC width (fixed 32, engine width)
//  CNT_W   16   width of frame/error/length counters
// PORTS
//  i_clk        in   1      clock
//  i_rst_n      in   1      async active-low reset
//  i_mode       in   1      0=generate, 1=check; sampled with SOP
//  i_data       in   DW     upstream word
//  i_vld        in   1      upstream valid
//  i_sop        in   1      first word of frame
//  i_eop        in   1      last word of frame
//  o_rdy        out  1      upstream ready
//  o_data       out  DW     downstream word
//  o_vld        out  1      downstream valid
//  o_sop        out  1      downstream first word
//  o_eop        out  1      downstream last word
//  i_rdy        in   1      downstream ready
//  o_crc_clr    out  1      engine clear (1-cycle pulse)
//  o_crc_d      out  DW     engine data
//  o_crc_d_vld  out  1      engine data valid
//  i_crc        in   DW     engine result (registered; reflects words accepted on prior edges)
//  o_chk_done   out  1      1-cycle pulse: check verdict valid
//  o_chk_ok     out  1      verdict (residue == 0), qualified by o_chk_done
//  o_err        out  1      1-cycle pulse: protocol error
//  o_frm_cnt    out  CNT_W  frames completed (wraps)
//  o_err_cnt    out  CNT_W  check failures + protocol errors (saturates)
//  o_len        out  CNT_W  word count of last completed input frame (incl. CRC word in check mode)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, latched mode=0.
//  Transfer: upstream on i_vld&o_rdy; downstream on o_vld&i_rdy.
//  FSM states and transitions:
//  - IDLE: o_rdy=0. On i_vld&i_sop: latch i_mode, go CLR. i_vld without i_sop: o_rdy=1 for one cycle,
//    word dropped, o_err pulses.
//  - CLR: o_crc_clr=1 for exactly one cycle; go DATA.
//  - DATA: combinational pass-through: o_rdy=i_rdy, o_vld=i_vld, o_data/o_sop=i_data/i_sop.
//    o_crc_d=i_data, o_crc_d_vld=i_vld&o_rdy. Gen mode forces o_eop=0; check mode passes i_eop.
//    On accepted EOP word: gen -> AUG, check -> WAIT. Length counter incremented per accepted word.
//  - AUG (gen only): o_crc_d=0, o_crc_d_vld=1 for one cycle (zero augmentation word); go WAIT.
//  - WAIT: one idle cycle for the engine register to settle.
//    Gen: capture i_crc into crc_q, go APPEND. Check: o_chk_done=1, o_chk_ok=(i_crc==0), go IDLE.
//  - APPEND: o_vld=1, o_data=crc_q, o_eop=1, o_sop=0. Hold until i_rdy; go IDLE.
//  Latency: gen CRC word presented 3 cycles after the EOP data word is accepted (AUG, WAIT, APPEND).
//    Check verdict 2 cycles after the EOP word is accepted.
//  Backpressure: i_rdy low stalls the DATA and APPEND states; the engine sees no valid while stalled.
//  SOP+EOP on the same word: legal one-word frame.
//  i_sop in DATA: word treated as data, o_err pulses, frame continues.
//  o_frm_cnt increments on leaving WAIT (check) or APPEND (gen).
//  o_err_cnt increments on o_err or on chk_done&!chk_ok. If both occur in the same cycle, increment by 1.
//  i_mode changes mid-frame are ignored (latched value used). No new frame accepted until IDLE.
//  Async reset mid-frame: immediate IDLE; partial frame discarded; no done/err pulse.
// TESTING
//  1. Gen 100 random words -> 101 words out, 100 data words unchanged, eop only on word 101, o_frm_cnt=1.
//  2. Loopback: feed test 1 output in check mode -> o_chk_done 2 cycles after EOP, o_chk_ok=1, o_len=101.
//  3. Flip bit 0 of word 37 in the check frame -> o_chk_ok=0, o_err_cnt=1.
//  4. Gen 1-word frame 0xDEADBEEF (sop&eop) with i_rdy toggling 1/0 every cycle.
//     -> 2 words out, CRC word held stable until accepted; check of it passes.
//  5. i_vld=1 without i_sop in IDLE -> word dropped, o_err pulse, o_err_cnt=1. SOP mid-frame -> o_err pulse.
//  6. Assert i_rst_n=0 after 10 words of a gen frame -> all outputs 0 next sample, counters 0.
//     Next full frame generates and checks correctly.

Source files
------------

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a 32-bit CRC engine: generate mode appends the CRC word to a frame,
// check mode passes the frame through and reports whether the engine residue is zero.
module crc_frame_ctrl #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mode,
    input  logic [DW-1:0]    i_data,
    input  logic             i_vld,
    input  logic             i_sop,
    input  logic             i_eop,
    output logic             o_rdy,
    output logic [DW-1:0]    o_data,
    output logic             o_vld,
    output logic             o_sop,
    output logic             o_eop,
    input  logic             i_rdy,
    output logic             o_crc_clr,
    output logic [DW-1:0]    o_crc_d,
    output logic             o_crc_d_vld,
    input  logic [DW-1:0]    i_crc,
    output logic             o_chk_done,
    output logic             o_chk_ok,
    output logic             o_err,
    output logic [CNT_W-1:0] o_frm_cnt,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_len
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_DATA,
        S_AUG,
        S_WAIT,
        S_APPEND
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_next;
    logic              r_mode;
    logic              r_first;
    logic [DW-1:0]     r_crc_q;
    logic [CNT_W-1:0]  r_len_cnt;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_frm_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_chk_done;
    logic              r_chk_ok;
    logic              r_err;

    logic              w_rdy;
    logic              w_vld;
    logic [DW-1:0]     w_data;
    logic              w_sop;
    logic              w_eop;
    logic              w_clr;
    logic [DW-1:0]     w_crc_d;
    logic              w_crc_d_vld;
    logic              w_err_evt;
    logic              w_chk_evt;
    logic              w_frm_done;
    logic              w_data_acc;
    logic              w_sop_start;
    logic              w_err_cnt_inc;

    always_comb begin
        w_state_next = r_state;
        w_rdy        = 1'b0;
        w_vld        = 1'b0;
        w_data       = '0;
        w_sop        = 1'b0;
        w_eop        = 1'b0;
        w_clr        = 1'b0;
        w_crc_d      = '0;
        w_crc_d_vld  = 1'b0;
        w_err_evt    = 1'b0;
        w_chk_evt    = 1'b0;
        w_frm_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A stray word outside a frame is swallowed so the source cannot lock up.
                if (i_vld) begin
                    if (i_sop) begin
                        w_state_next = S_CLR;
                    end else begin
                        w_rdy     = 1'b1;
                        w_err_evt = 1'b1;
                    end
                end
            end
            S_CLR: begin
                w_clr        = 1'b1;
                w_state_next = S_DATA;
            end
            S_DATA: begin
                w_rdy       = i_rdy;
                w_vld       = i_vld;
                w_data      = i_data;
                w_sop       = i_sop;
                w_eop       = r_mode & i_eop;
                w_crc_d     = i_data;
                w_crc_d_vld = i_vld & i_rdy;
                if (i_vld && i_rdy) begin
                    if (i_sop && !r_first) begin
                        w_err_evt = 1'b1;
                    end
                    if (i_eop) begin
                        w_state_next = r_mode ? S_WAIT : S_AUG;
                    end
                end
            end
            S_AUG: begin
                w_crc_d_vld  = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_mode) begin
                    w_chk_evt    = 1'b1;
                    w_frm_done   = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_APPEND;
                end
            end
            S_APPEND: begin
                w_vld  = 1'b1;
                w_data = r_crc_q;
                w_eop  = 1'b1;
                if (i_rdy) begin
                    w_frm_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_data_acc    = (r_state == S_DATA) && i_vld && i_rdy;
    assign w_sop_start   = (r_state == S_IDLE) && i_vld && i_sop;
    assign w_err_cnt_inc = r_err || (r_chk_done && !r_chk_ok);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_first <= 1'b0;
            r_crc_q <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_sop_start) begin
                r_mode <= i_mode;
            end
            if (r_state == S_CLR) begin
                r_first <= 1'b1;
            end else if (w_data_acc) begin
                r_first <= 1'b0;
            end
            // The engine output has absorbed the zero augmentation word by now.
            if (r_state == S_WAIT && !r_mode) begin
                r_crc_q <= i_crc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len_cnt  <= '0;
            r_len      <= '0;
            r_frm_cnt  <= '0;
            r_err_cnt  <= '0;
            r_chk_done <= 1'b0;
            r_chk_ok   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_CLR) begin
                r_len_cnt <= '0;
            end else if (w_data_acc) begin
                r_len_cnt <= r_len_cnt + CNT_ONE;
                if (i_eop) begin
                    r_len <= r_len_cnt + CNT_ONE;
                end
            end
            r_chk_done <= w_chk_evt;
            r_chk_ok   <= w_chk_evt && (i_crc == '0);
            r_err      <= w_err_evt;
            if (w_frm_done) begin
                r_frm_cnt <= r_frm_cnt + CNT_ONE;
            end
            // Protocol error and failed verdict in the same cycle count once.
            if (w_err_cnt_inc && (r_err_cnt != CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
        end
    end

    assign o_rdy       = w_rdy;
    assign o_data      = w_data;
    assign o_vld       = w_vld;
    assign o_sop       = w_sop;
    assign o_eop       = w_eop;
    assign o_crc_clr   = w_clr;
    assign o_crc_d     = w_crc_d;
    assign o_crc_d_vld = w_crc_d_vld;
    assign o_chk_done  = r_chk_done;
    assign o_chk_ok    = r_chk_ok;
    assign o_err       = r_err;
    assign o_frm_cnt   = r_frm_cnt;
    assign o_err_cnt   = r_err_cnt;
    assign o_len       = r_len;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Bench for crc_frame_ctrl: models the CRC engine, drives random frames in both modes and
// checks outputs against a polynomial long-division reference.
module tb_crc_frame_ctrl;

    localparam int DW    = 32;
    localparam int CNT_W = 16;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_mode;
    logic [DW-1:0]    i_data;
    logic             i_vld;
    logic             i_sop;
    logic             i_eop;
    logic             o_rdy;
    logic [DW-1:0]    o_data;
    logic             o_vld;
    logic             o_sop;
    logic             o_eop;
    logic             i_rdy;
    logic             o_crc_clr;
    logic [DW-1:0]    o_crc_d;
    logic             o_crc_d_vld;
    logic [DW-1:0]    i_crc;
    logic             o_chk_done;
    logic             o_chk_ok;
    logic             o_err;
    logic [CNT_W-1:0] o_frm_cnt;
    logic [CNT_W-1:0] o_err_cnt;
    logic [CNT_W-1:0] o_len;

    crc_frame_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_data(i_data),
        .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop), .o_rdy(o_rdy),
        .o_data(o_data), .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop),
        .i_rdy(i_rdy), .o_crc_clr(o_crc_clr), .o_crc_d(o_crc_d),
        .o_crc_d_vld(o_crc_d_vld), .i_crc(i_crc), .o_chk_done(o_chk_done),
        .o_chk_ok(o_chk_ok), .o_err(o_err), .o_frm_cnt(o_frm_cnt),
        .o_err_cnt(o_err_cnt), .o_len(o_len)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int bp_mode  = 0;   // 0: always ready, 1: random, 2: toggle
    int eop_cyc  = -1;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Engine model: remainder register, one 32-bit word shifted in per valid cycle.
    function automatic logic [31:0] eng_step(input logic [31:0] r, input logic [31:0] d);
        logic [31:0] x = r;
        logic        fb;
        for (int b = 31; b >= 0; b--) begin
            fb = x[31];
            x  = {x[30:0], d[b]};
            if (fb) x = x ^ POLY;
        end
        return x;
    endfunction

    logic [31:0] eng_r;
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)          eng_r <= '0;
        else if (o_crc_clr)    eng_r <= '0;
        else if (o_crc_d_vld)  eng_r <= eng_step(eng_r, o_crc_d);
    end
    assign i_crc = eng_r;

    // Reference: remainder of M(x)*x^32 modulo the generator, by long division over the bit string.
    function automatic logic [31:0] ref_crc(input logic [31:0] msg[$]);
        bit          bits[$];
        logic [31:0] rem = '0;
        logic        top;
        foreach (msg[k]) for (int b = 31; b >= 0; b--) bits.push_back(msg[k][b]);
        repeat (32) bits.push_back(1'b0);
        foreach (bits[k]) begin
            top = rem[31];
            rem = {rem[30:0], bits[k]};
            if (top) rem = rem ^ POLY;
        end
        return rem;
    endfunction

    // Negedge monitor: inputs are stable and combinational outputs settled here.
    logic [31:0] out_d[$];
    bit          out_sop[$];
    bit          out_eop[$];
    int          crc_cyc     = -1;
    int          done_cnt    = 0;
    int          done_cyc    = -1;
    bit          last_ok     = 1'b0;
    int          err_pulses  = 0;
    bit          hold_pend   = 1'b0;
    logic [31:0] hold_data   = '0;
    int          hold_bad    = 0;

    always @(negedge i_clk) begin
        if (o_vld && i_rdy) begin
            out_d.push_back(o_data);
            out_sop.push_back(o_sop);
            out_eop.push_back(o_eop);
        end
        if (o_vld && o_eop && crc_cyc < 0) crc_cyc = cyc;
        if (o_vld && o_eop) begin
            if (hold_pend && o_data !== hold_data) hold_bad++;
            hold_pend = !i_rdy;
            hold_data = o_data;
        end else begin
            hold_pend = 1'b0;
        end
        if (o_chk_done) begin
            done_cnt++;
            done_cyc = cyc;
            last_ok  = o_chk_ok;
        end
        if (o_err) err_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (bp_mode == 1)      i_rdy = ($urandom_range(0, 9) < 7);
        else if (bp_mode == 2) i_rdy = ~i_rdy;
        else                   i_rdy = 1'b1;
    endtask

    task automatic clear_mon();
        out_d.delete();
        out_sop.delete();
        out_eop.delete();
        crc_cyc = -1;
    endtask

    // Sends words; i_mode flips after the first word to show the mode is latched at SOP.
    task automatic send_frame(input bit mode, input logic [31:0] w[$], input int sop_at,
                              input int stop_after);
        int idx    = 0;
        int budget = 0;
        while (idx < w.size() && idx < stop_after) begin
            i_mode = (idx == 0) ? mode : ~mode;
            i_vld  = 1'b1;
            i_data = w[idx];
            i_sop  = (idx == 0) || (idx == sop_at);
            i_eop  = (idx == w.size() - 1);
            @(negedge i_clk);
            if (o_rdy) begin
                if (i_eop) eop_cyc = cyc;
                idx++;
            end
            tick();
            budget++;
            if (budget > 2000) begin
                chk("send_timeout", 32'(budget), 32'd0);
                break;
            end
        end
        i_vld = 1'b0;
        i_sop = 1'b0;
        i_eop = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int t = 0;
        while (out_d.size() < n && t < 500) begin
            tick();
            t++;
        end
        chk("drain_count", 32'(out_d.size()), 32'(n));
        tick();
    endtask

    task automatic wait_done(input int prev);
        int t = 0;
        while (done_cnt == prev && t < 100) begin
            tick();
            t++;
        end
        chk("done_seen", 32'(done_cnt), 32'(prev + 1));
        tick();
    endtask

    logic [31:0] wq[$];
    logic [31:0] gen_out[$];
    logic [31:0] exp_crc;
    int          nd;
    int          eops;
    int          sops;
    int          prev_err;

    initial begin
        i_rst_n = 1'b0;
        i_mode  = 1'b0;
        i_data  = '0;
        i_vld   = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        i_rdy   = 1'b1;
        repeat (3) tick();
        chk("rst_o_rdy", 32'(o_rdy), 32'd0);
        chk("rst_o_vld", 32'(o_vld), 32'd0);
        chk("rst_o_clr", 32'(o_crc_clr), 32'd0);
        chk("rst_frm_cnt", 32'(o_frm_cnt), 32'd0);
        chk("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("rst_len", 32'(o_len), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) tick();

        // Generate 100 random words under random backpressure.
        wq.delete();
        for (int k = 0; k < 100; k++) wq.push_back($urandom());
        exp_crc = ref_crc(wq);
        clear_mon();
        bp_mode = 1;
        send_frame(1'b0, wq, -1, 1000);
        wait_out(101);
        bp_mode = 0;
        tick();
        $display("gen frame: words_in=100 words_out=%0d crc=%h", out_d.size(), out_d[out_d.size()-1]);
        nd = (out_d.size() < 100) ? out_d.size() : 100;
        for (int k = 0; k < nd; k++) chk($sformatf("gen_data_%0d", k), out_d[k], wq[k]);
        eops = 0;
        sops = 0;
        foreach (out_eop[k]) eops += int'(out_eop[k]);
        foreach (out_sop[k]) sops += int'(out_sop[k]);
        chk("gen_eop_count", 32'(eops), 32'd1);
        chk("gen_eop_last", 32'(out_eop[out_eop.size()-1]), 32'd1);
        chk("gen_sop_count", 32'(sops), 32'd1);
        chk("gen_crc_word", out_d[out_d.size()-1], exp_crc);
        chk("gen_crc_latency", 32'(crc_cyc - eop_cyc), 32'd3);
        chk("gen_frm_cnt", 32'(o_frm_cnt), 32'd1);
        chk("gen_len", 32'(o_len), 32'd100);
        chk("gen_err_cnt", 32'(o_err_cnt), 32'd0);
        gen_out = out_d;

        // Loopback the generated frame in check mode.
        clear_mon();
        send_frame(1'b1, gen_out, -1, 1000);
        wait_done(0);
        $display("check frame: len=%0d ok=%0d", o_len, last_ok);
        chk("chk_latency", 32'(done_cyc - eop_cyc), 32'd2);
        chk("chk_ok", 32'(last_ok), 32'd1);
        chk("chk_len", 32'(o_len), 32'd101);
        chk("chk_passthru_cnt", 32'(out_d.size()), 32'd101);
        chk("chk_passthru_eop", 32'(out_eop[out_eop.size()-1]), 32'd1);
        chk("chk_frm_cnt", 32'(o_frm_cnt), 32'd2);
        chk("chk_err_cnt", 32'(o_err_cnt), 32'd0);

        // Corrupt bit 0 of word 37.
        wq = gen_out;
        wq[37] = wq[37] ^ 32'd1;
        clear_mon();
        send_frame(1'b1, wq, -1, 1000);
        wait_done(1);
        $display("check frame (corrupted): len=%0d ok=%0d", o_len, last_ok);
        chk("bad_ok", 32'(last_ok), 32'd0);
        chk("bad_err_cnt", 32'(o_err_cnt), 32'd1);
        chk("bad_frm_cnt", 32'(o_frm_cnt), 32'd3);

        // One-word frame with downstream ready toggling every cycle.
        wq.delete();
        wq.push_back(32'hDEAD_BEEF);
        exp_crc = ref_crc(wq);
        clear_mon();
        hold_bad = 0;
        bp_mode  = 2;
        send_frame(1'b0, wq, -1, 1000);
        wait_out(2);
        bp_mode = 0;
        tick();
        $display("gen 1-word frame: words_out=%0d crc=%h", out_d.size(), out_d[out_d.size()-1]);
        chk("one_data", out_d[0], 32'hDEAD_BEEF);
        chk("one_crc", out_d[out_d.size()-1], exp_crc);
        chk("one_hold_stable", 32'(hold_bad), 32'd0);
        chk("one_frm_cnt", 32'(o_frm_cnt), 32'd4);
        gen_out = out_d;
        clear_mon();
        send_frame(1'b1, gen_out, -1, 1000);
        wait_done(2);
        $display("check 1-word frame: len=%0d ok=%0d", o_len, last_ok);
        chk("one_chk_ok", 32'(last_ok), 32'd1);
        chk("one_chk_len", 32'(o_len), 32'd2);
        chk("one_err_cnt", 32'(o_err_cnt), 32'd1);

        // Stray word in IDLE is dropped with an error pulse.
        prev_err = err_pulses;
        i_vld  = 1'b1;
        i_sop  = 1'b0;
        i_data = $urandom();
        @(negedge i_clk);
        chk("drop_rdy", 32'(o_rdy), 32'd1);
        tick();
        i_vld = 1'b0;
        chk("drop_err_pulse", 32'(o_err), 32'd1);
        tick();
        $display("stray word dropped: err_pulses=%0d", err_pulses - prev_err);
        chk("drop_err_gone", 32'(o_err), 32'd0);
        chk("drop_err_cnt", 32'(o_err_cnt), 32'd2);

        // SOP on a middle word: flagged, frame continues.
        wq.delete();
        for (int k = 0; k < 5; k++) wq.push_back($urandom());
        exp_crc = ref_crc(wq);
        clear_mon();
        prev_err = err_pulses;
        send_frame(1'b0, wq, 2, 1000);
        wait_out(6);
        tick();
        $display("gen frame with mid SOP: words_out=%0d crc=%h", out_d.size(), out_d[out_d.size()-1]);
        chk("midsop_err_pulses", 32'(err_pulses - prev_err), 32'd1);
        chk("midsop_err_cnt", 32'(o_err_cnt), 32'd3);
        chk("midsop_crc", out_d[out_d.size()-1], exp_crc);
        chk("midsop_frm_cnt", 32'(o_frm_cnt), 32'd6);

        // Reset after 10 words of a generate frame.
        wq.delete();
        for (int k = 0; k < 30; k++) wq.push_back($urandom());
        clear_mon();
        send_frame(1'b0, wq, -1, 10);
        i_rst_n = 1'b0;
        #2;
        $display("async reset mid-frame after %0d words", out_d.size());
        chk("ar_o_vld", 32'(o_vld), 32'd0);
        chk("ar_o_rdy", 32'(o_rdy), 32'd0);
        chk("ar_o_crc_d_vld", 32'(o_crc_d_vld), 32'd0);
        chk("ar_frm_cnt", 32'(o_frm_cnt), 32'd0);
        chk("ar_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("ar_len", 32'(o_len), 32'd0);
        prev_err = err_pulses;
        nd       = done_cnt;
        tick();
        i_rst_n = 1'b1;
        repeat (3) tick();
        chk("ar_no_err_pulse", 32'(err_pulses), 32'(prev_err));
        chk("ar_no_done_pulse", 32'(done_cnt), 32'(nd));

        wq.delete();
        for (int k = 0; k < 20; k++) wq.push_back($urandom());
        exp_crc = ref_crc(wq);
        clear_mon();
        send_frame(1'b0, wq, -1, 1000);
        wait_out(21);
        $display("gen frame after reset: words_out=%0d crc=%h", out_d.size(), out_d[out_d.size()-1]);
        chk("post_crc", out_d[out_d.size()-1], exp_crc);
        gen_out = out_d;
        clear_mon();
        send_frame(1'b1, gen_out, -1, 1000);
        wait_done(nd);
        $display("check frame after reset: len=%0d ok=%0d", o_len, last_ok);
        chk("post_chk_ok", 32'(last_ok), 32'd1);
        chk("post_frm_cnt", 32'(o_frm_cnt), 32'd2);
        chk("post_err_cnt", 32'(o_err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
